// File: rtl/load_store_sequencer.sv
// Byte-serial load/store sequencer: turns one RV32I LB/LH/LW/LBU/LHU/SB/SH/SW request
// into 1, 2 or 4 single-byte memory accesses, then returns one response pulse.
module load_store_sequencer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_funct3,
    input  logic                     req_store,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]               mem_wd,
    output logic                     mem_we,
    input  logic [7:0]               mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [2:0]               funct3_q;
    logic                     store_q;
    logic                     err_q;
    logic [1:0]               idx;
    logic [1:0]               last_idx;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic                     req_legal;

    function automatic logic is_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

    assign req_legal = is_legal(req_store, req_funct3);

    always_comb begin
        last_idx = 2'd3;
        case (funct3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // result_q is cleared on acceptance, so lanes beyond N are already zero
    // and the unsigned/word cases need no masking.
    always_comb begin
        load_ext = '0;
        if (!store_q && !err_q) begin
            case (funct3_q)
                3'b000:  load_ext = {{(DATA_WIDTH-8){result_q[7]}}, result_q[7:0]};
                3'b001:  load_ext = {{(DATA_WIDTH-16){result_q[15]}}, result_q[15:0]};
                default: load_ext = result_q;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        mem_addr   = '0;
        mem_wd     = '0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_legal ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                mem_addr = addr_q + ADDRESS_WIDTH'(idx);
                if (store_q) begin
                    mem_wd = wdata_q[8*idx +: 8];
                    mem_we = 1'b1;
                end
                if (idx == last_idx) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_data  = load_ext;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            result_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        store_q  <= req_store;
                        err_q    <= !req_legal;
                        idx      <= '0;
                        result_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!store_q) begin
                        result_q[8*idx +: 8] <= mem_rd;
                    end
                    idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
